// File: rtl/locked_adder_key_sweep_ctrl_if.sv
// Bundle between the key-sweep sequencer and its vector RAM, locked DUT and golden adder.
// Latency: none, wires only.
// Backpressure: none; the sequencer owns all timing. LKSWEEP_BITERR_EN adds bit_err_count_o.
`timescale 1ns/1ps
interface locked_adder_key_sweep_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 32,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 14
);
  logic              start_i;
  logic              abort_i;
  logic [KEY_W-1:0]  key_i;
  logic              busy_o;
  logic              done_o;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] add1_o;
  logic [DATA_W-1:0] add2_o;
  logic [KEY_W-1:0]  keyinput_o;
  logic [DATA_W:0]   dut_result_i;
  logic [DATA_W:0]   golden_result_i;
  logic [CNT_W-1:0]  err_count_o;
`ifdef LKSWEEP_BITERR_EN
  logic [CNT_W+4:0]  bit_err_count_o;
`endif

  // Sequencer side.
  modport master (
    input  start_i, abort_i, key_i, mem_data_i, dut_result_i, golden_result_i,
`ifdef LKSWEEP_BITERR_EN
    output bit_err_count_o,
`endif
    output busy_o, done_o, mem_rd_o, mem_addr_o, add1_o, add2_o, keyinput_o, err_count_o
  );

  // Harness side: controller, RAM, DUT and golden model.
  modport slave (
    output start_i, abort_i, key_i, mem_data_i, dut_result_i, golden_result_i,
`ifdef LKSWEEP_BITERR_EN
    input  bit_err_count_o,
`endif
    input  busy_o, done_o, mem_rd_o, mem_addr_o, add1_o, add2_o, keyinput_o, err_count_o
  );
endinterface

// File: rtl/locked_adder_key_sweep_ctrl.sv
// Key-sweep sequencer: streams NUM_VEC operand pairs into locked and golden adders, counts mismatching vectors.
// Latency: 4+ADDER_LAT cycles per vector; start acceptance to done_o is NUM_VEC*(4+ADDER_LAT)+1 cycles.
// Backpressure: none; RAM data expected one cycle after mem_rd_o, start_i ignored while busy, abort_i returns to IDLE.
// Optional feature macro LKSWEEP_BITERR_EN: adds bit_err_count_o, a saturating popcount of result differences.
`timescale 1ns/1ps
module locked_adder_key_sweep_ctrl #(
  parameter int DATA_W    = 16,
  parameter int KEY_W     = 32,
  parameter int NUM_VEC   = 10000,
  parameter int ADDR_W    = 15,
  parameter int ADDER_LAT = 0,
  parameter int CNT_W     = 14
) (
  input logic                          clk,
  input logic                          rst,
  locked_adder_key_sweep_ctrl_if.master bus
);
  // Vector index is half the word address: even word = operand A, odd word = operand B.
  localparam int VEC_W = ADDR_W - 1;
  localparam int LAT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, APPLY, WAIT, CHECK, DONE} state_t;

  state_t            state_q, state_nxt;
  logic [VEC_W-1:0]  k_q;
  logic [LAT_W-1:0]  wait_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] add1_q, add2_q;
  logic [CNT_W-1:0]  err_q;

  logic              accept, ld_a, ld_b, check, last_vec;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W:0]   diff;
  logic              mismatch;

  assign last_vec = (k_q == VEC_W'(NUM_VEC - 1));
  assign diff     = bus.dut_result_i ^ bus.golden_result_i;
  assign mismatch = |diff;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and per-state strobes; abort pulls any busy state back to IDLE.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    check     = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          accept    = 1'b1;
          state_nxt = FETCH_A;
        end
      end
      FETCH_A: begin
        mem_rd    = 1'b1;
        mem_addr  = {k_q, 1'b0};
        state_nxt = FETCH_B;
      end
      FETCH_B: begin
        ld_a      = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = {k_q, 1'b1};
        state_nxt = APPLY;
      end
      APPLY: begin
        ld_b      = 1'b1;
        state_nxt = (ADDER_LAT > 0) ? WAIT : CHECK;
      end
      WAIT: begin
        if (wait_q == LAT_W'(ADDER_LAT - 1)) state_nxt = CHECK;
      end
      CHECK: begin
        check     = 1'b1;
        state_nxt = last_vec ? DONE : FETCH_A;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort_i && state_q != IDLE && state_q != DONE) state_nxt = IDLE;
  end

  // Key latch, operand registers, vector index, latency counter and mismatch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      wait_q <= '0;
      key_q  <= '0;
      add1_q <= '0;
      add2_q <= '0;
      err_q  <= '0;
    end else begin
      if (accept) begin
        key_q <= bus.key_i;
        err_q <= '0;
        k_q   <= '0;
      end
      if (ld_a) add1_q <= bus.mem_data_i;
      if (ld_b) begin
        add2_q <= bus.mem_data_i;
        wait_q <= '0;
      end else if (state_q == WAIT) begin
        wait_q <= wait_q + LAT_W'(1);
      end
      if (check) begin
        if (mismatch && err_q != '1) err_q <= err_q + CNT_W'(1);
        if (!last_vec) k_q <= k_q + VEC_W'(1);
      end
    end
  end

`ifdef LKSWEEP_BITERR_EN
  localparam int BERR_W = CNT_W + 5;
  localparam int POP_W  = $clog2(DATA_W + 2);

  logic [BERR_W-1:0] berr_q;
  logic [POP_W-1:0]  pop;
  logic [BERR_W:0]   berr_sum;

  // Number of differing result bits, added to the running total with a carry bit for saturation.
  always_comb begin
    pop = '0;
    for (int i = 0; i <= DATA_W; i++) pop = pop + POP_W'(diff[i]);
    berr_sum = {1'b0, berr_q} + (BERR_W + 1)'(pop);
  end

  // Bit-error accumulator: cleared on start, frozen outside CHECK.
  always_ff @(posedge clk) begin
    if (rst)         berr_q <= '0;
    else if (accept) berr_q <= '0;
    else if (check)  berr_q <= berr_sum[BERR_W] ? '1 : berr_sum[BERR_W-1:0];
  end

  assign bus.bit_err_count_o = berr_q;
`endif

  assign bus.busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.mem_rd_o    = mem_rd;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.add1_o      = add1_q;
  assign bus.add2_o      = add2_q;
  assign bus.keyinput_o  = key_q;
  assign bus.err_count_o = err_q;
endmodule

// File: tb/tb_locked_adder_key_sweep_ctrl.sv
// Bench for the key-sweep sequencer: three configurations (LAT 0, LAT 2, saturating 2-bit counter).
// Latency: expected done cycle, busy window and read sequence come from the per-vector cost formula.
// Backpressure: abort, ignored restart and mid-pass reset are driven alongside normal passes.
`timescale 1ns/1ps
module tb_locked_adder_key_sweep_ctrl;
  localparam int DW = 16;
  localparam int KW = 32;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  locked_adder_key_sweep_ctrl_if #(.DATA_W(DW), .KEY_W(KW), .ADDR_W(AW), .CNT_W(14)) if0 ();
  locked_adder_key_sweep_ctrl_if #(.DATA_W(DW), .KEY_W(KW), .ADDR_W(AW), .CNT_W(14)) if1 ();
  locked_adder_key_sweep_ctrl_if #(.DATA_W(DW), .KEY_W(KW), .ADDR_W(AW), .CNT_W(2))  if2 ();

  locked_adder_key_sweep_ctrl #(.DATA_W(DW), .KEY_W(KW), .NUM_VEC(4), .ADDR_W(AW), .ADDER_LAT(0), .CNT_W(14))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  locked_adder_key_sweep_ctrl #(.DATA_W(DW), .KEY_W(KW), .NUM_VEC(4), .ADDR_W(AW), .ADDER_LAT(2), .CNT_W(14))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  locked_adder_key_sweep_ctrl #(.DATA_W(DW), .KEY_W(KW), .NUM_VEC(6), .ADDR_W(AW), .ADDER_LAT(0), .CNT_W(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  // Environment: vector RAMs and per-vector xor corruption applied to the locked adder result.
  logic [15:0] ram [3][16];
  logic [16:0] xm  [3][8];
  logic [2:0]  start_v, abort_v;
  logic [31:0] key_v [3];
  logic [2:0]  cv0, cv1, cv2;
  logic [16:0] g1a, g1b, d1a, d1b;

  assign if0.start_i = start_v[0];
  assign if1.start_i = start_v[1];
  assign if2.start_i = start_v[2];
  assign if0.abort_i = abort_v[0];
  assign if1.abort_i = abort_v[1];
  assign if2.abort_i = abort_v[2];
  assign if0.key_i   = key_v[0];
  assign if1.key_i   = key_v[1];
  assign if2.key_i   = key_v[2];

  always @(posedge clk) begin
    if (if0.mem_rd_o) begin
      if0.mem_data_i <= ram[0][if0.mem_addr_o[3:0]];
      cv0 <= if0.mem_addr_o[3:1];
    end
  end
  assign if0.golden_result_i = {1'b0, if0.add1_o} + {1'b0, if0.add2_o};
  assign if0.dut_result_i    = if0.golden_result_i ^ xm[0][cv0];

  // Two-stage pipelined adders; corruption is decided when the operands enter the pipe.
  always @(posedge clk) begin
    if (if1.mem_rd_o) begin
      if1.mem_data_i <= ram[1][if1.mem_addr_o[3:0]];
      cv1 <= if1.mem_addr_o[3:1];
    end
    g1a <= {1'b0, if1.add1_o} + {1'b0, if1.add2_o};
    g1b <= g1a;
    d1a <= ({1'b0, if1.add1_o} + {1'b0, if1.add2_o}) ^ xm[1][cv1];
    d1b <= d1a;
  end
  assign if1.golden_result_i = g1b;
  assign if1.dut_result_i    = d1b;

  always @(posedge clk) begin
    if (if2.mem_rd_o) begin
      if2.mem_data_i <= ram[2][if2.mem_addr_o[3:0]];
      cv2 <= if2.mem_addr_o[3:1];
    end
  end
  assign if2.golden_result_i = {1'b0, if2.add1_o} + {1'b0, if2.add2_o};
  assign if2.dut_result_i    = if2.golden_result_i ^ xm[2][cv2];

  // Observed outputs gathered by instance index.
  logic [2:0]  busy_v, done_v, rd_v;
  logic [14:0] addr_v [3];
  logic [31:0] keyo_v [3];
  logic [15:0] a1_v [3], a2_v [3];
  logic [13:0] err_v [3];
`ifdef LKSWEEP_BITERR_EN
  logic [18:0] berr_v [3];
`endif
  always_comb begin
    busy_v    = {if2.busy_o, if1.busy_o, if0.busy_o};
    done_v    = {if2.done_o, if1.done_o, if0.done_o};
    rd_v      = {if2.mem_rd_o, if1.mem_rd_o, if0.mem_rd_o};
    addr_v[0] = if0.mem_addr_o;   addr_v[1] = if1.mem_addr_o;   addr_v[2] = if2.mem_addr_o;
    keyo_v[0] = if0.keyinput_o;   keyo_v[1] = if1.keyinput_o;   keyo_v[2] = if2.keyinput_o;
    a1_v[0]   = if0.add1_o;       a1_v[1]   = if1.add1_o;       a1_v[2]   = if2.add1_o;
    a2_v[0]   = if0.add2_o;       a2_v[1]   = if1.add2_o;       a2_v[2]   = if2.add2_o;
    err_v[0]  = if0.err_count_o;  err_v[1]  = if1.err_count_o;  err_v[2]  = {12'd0, if2.err_count_o};
`ifdef LKSWEEP_BITERR_EN
    berr_v[0] = if0.bit_err_count_o;
    berr_v[1] = if1.bit_err_count_o;
    berr_v[2] = {12'd0, if2.bit_err_count_o};
`endif
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pass on instance idx; c_ab>0 aborts in that cycle, c_rs>0 pulses start with another key.
  task automatic run_pass(input int idx, input int nvec, input int lat, input int cntw,
                          input logic [31:0] key, input int c_ab, input int c_rs);
    int p, done_c, last, e_err, e_berr, e_nrd, nrd, bad_busy, bad_done, bad_addr, n_done, done_at;
    logic exp_busy, exp_done;
    p        = 4 + lat;
    done_c   = nvec * p + 1;
    last     = (c_ab > 0) ? c_ab + 3 : done_c + 2;
    e_err    = 0;
    e_berr   = 0;
    for (int v = 0; v < nvec; v++) begin
      if (c_ab == 0 || (v + 1) * p < c_ab) begin
        if (xm[idx][v] != 17'd0) e_err++;
        e_berr += $countones(xm[idx][v]);
      end
    end
    if (e_err > (1 << cntw) - 1) e_err = (1 << cntw) - 1;
    if (e_berr > (1 << (cntw + 5)) - 1) e_berr = (1 << (cntw + 5)) - 1;
    e_nrd = 0;
    if (c_ab == 0) e_nrd = 2 * nvec;
    else for (int c = 1; c <= c_ab; c++) if ((c - 1) % p < 2) e_nrd++;
    nrd = 0; bad_busy = 0; bad_done = 0; bad_addr = 0; n_done = 0; done_at = 0;

    key_v[idx]   = key;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    key_v[idx]   = $urandom;
    expect_eq($sformatf("u%0d err_clear", idx), 32'(err_v[idx]), 32'd0);
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      exp_busy = (c_ab > 0) ? (c <= c_ab) : (c < done_c);
      exp_done = (c_ab == 0) && (c == done_c);
      if (busy_v[idx] !== exp_busy) bad_busy++;
      if (done_v[idx] !== exp_done) bad_done++;
      if (done_v[idx] === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (rd_v[idx] === 1'b1) begin
        if (int'(addr_v[idx]) != nrd) bad_addr++;
        nrd++;
      end
      abort_v[idx] = (c == c_ab);
      start_v[idx] = (c == c_rs);
      if (c == c_rs) key_v[idx] = (key == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
    end
    abort_v[idx] = 1'b0;
    start_v[idx] = 1'b0;

    expect_eq($sformatf("u%0d busy_window", idx), bad_busy, 0);
    expect_eq($sformatf("u%0d done_pattern", idx), bad_done, 0);
    expect_eq($sformatf("u%0d done_cycle", idx), done_at, (c_ab > 0) ? 0 : done_c);
    expect_eq($sformatf("u%0d done_count", idx), n_done, (c_ab > 0) ? 0 : 1);
    expect_eq($sformatf("u%0d addr_seq", idx), bad_addr, 0);
    expect_eq($sformatf("u%0d rd_count", idx), nrd, e_nrd);
    expect_eq($sformatf("u%0d err_count", idx), 32'(err_v[idx]), e_err);
`ifdef LKSWEEP_BITERR_EN
    expect_eq($sformatf("u%0d bit_err_count", idx), 32'(berr_v[idx]), e_berr);
`endif
    expect_eq($sformatf("u%0d keyinput", idx), keyo_v[idx], key);
    if (c_ab == 0) begin
      expect_eq($sformatf("u%0d add1_hold", idx), 32'(a1_v[idx]), 32'(ram[idx][2 * nvec - 2]));
      expect_eq($sformatf("u%0d add2_hold", idx), 32'(a2_v[idx]), 32'(ram[idx][2 * nvec - 1]));
    end
  endtask

  task automatic check_zero(input int idx, input string when);
    expect_eq($sformatf("%s u%0d busy", when, idx), 32'(busy_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d done", when, idx), 32'(done_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d mem_rd", when, idx), 32'(rd_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d mem_addr", when, idx), 32'(addr_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d add1", when, idx), 32'(a1_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d add2", when, idx), 32'(a2_v[idx]), 32'd0);
    expect_eq($sformatf("%s u%0d keyinput", when, idx), keyo_v[idx], 32'd0);
    expect_eq($sformatf("%s u%0d err", when, idx), 32'(err_v[idx]), 32'd0);
`ifdef LKSWEEP_BITERR_EN
    expect_eq($sformatf("%s u%0d bit_err", when, idx), 32'(berr_v[idx]), 32'd0);
`endif
  endtask

  initial begin
    int n_done_after;
    logic [15:0] base [8];
    base = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      key_v[i] = 32'd0;
      for (int w = 0; w < 16; w++) ram[i][w] = 16'd0;
      for (int v = 0; v < 8; v++)  xm[i][v] = 17'd0;
    end
    start_v = '0;
    abort_v = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Reference vectors, all matching.
    for (int w = 0; w < 8; w++) begin ram[0][w] = base[w]; ram[1][w] = base[w]; end
    run_pass(0, 4, 0, 14, 32'hA5A5_0001, 0, 0);
    // Vectors 1 and 3 corrupted in the LSB.
    xm[0][1] = 17'h1;
    xm[0][3] = 17'h1;
    run_pass(0, 4, 0, 14, 32'h0BAD_F00D, 0, 0);
    // Restart attempt while busy must be ignored.
    run_pass(0, 4, 0, 14, 32'h1430_BA8E, 0, 3);
    // Every vector mismatching, abort after two checked vectors, then a fresh pass clears the count.
    for (int v = 0; v < 4; v++) xm[0][v] = 17'h1_0001;
    run_pass(0, 4, 0, 14, 32'h1234_5678, 9, 0);
    for (int v = 0; v < 4; v++) xm[0][v] = 17'd0;
    run_pass(0, 4, 0, 14, 32'h8765_4321, 0, 0);
    // Pipelined adders.
    xm[1][2] = 17'h0_0F00;
    run_pass(1, 4, 2, 14, 32'hCAFE_0002, 0, 0);
    // Two-bit counter saturates with all six vectors mismatching.
    for (int w = 0; w < 12; w++) ram[2][w] = 16'($urandom);
    for (int v = 0; v < 6; v++)  xm[2][v] = 17'h1;
    run_pass(2, 6, 0, 2, 32'hDEAD_BEEF, 0, 0);

    // Randomised passes across all three configurations.
    for (int r = 0; r < 15; r++) begin
      int idx, nvec, lat, cntw, p, cab, crs;
      idx  = r % 3;
      nvec = (idx == 2) ? 6 : 4;
      lat  = (idx == 1) ? 2 : 0;
      cntw = (idx == 2) ? 2 : 14;
      p    = 4 + lat;
      for (int w = 0; w < 2 * nvec; w++) ram[idx][w] = 16'($urandom);
      for (int v = 0; v < nvec; v++) xm[idx][v] = ($urandom_range(0, 1) == 1) ? 17'($urandom) : 17'd0;
      cab = 0;
      crs = 0;
      if ($urandom_range(0, 2) == 0) begin
        cab = $urandom_range(1, nvec * p);
        if (cab % p == 0) cab--;
      end
      if ($urandom_range(0, 1) == 1) begin
        crs = $urandom_range(2, nvec * p - 1);
        if (cab != 0 && crs >= cab) crs = 0;
      end
      run_pass(idx, nvec, lat, cntw, $urandom, cab, crs);
    end

    // Reset in the middle of a pass.
    for (int v = 0; v < 6; v++) xm[2][v] = 17'h1;
    key_v[2]   = 32'h5555_AAAA;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    repeat (9) @(negedge clk);
    expect_eq("u2 err_before_reset", 32'(err_v[2]), 32'd2);
    expect_eq("u2 busy_before_reset", 32'(busy_v[2]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero(2, "midpass_reset");
    rst = 1'b0;
    n_done_after = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_v[2] === 1'b1 || busy_v[2] === 1'b1) n_done_after++;
    end
    expect_eq("u2 idle_after_reset", n_done_after, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
